// File: rtl/alu_mc_if.sv
// Request/response bundle between the execute-stage controller and alu_mc.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ALUControl;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [3:0]       ALUFlags;

    modport master (
        output Start, a, b, ALUControl,
        input  Busy, Done, Result, ALUFlags
    );

    modport slave (
        input  Start, a, b, ALUControl,
        output Busy, Done, Result, ALUFlags
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative shift-add multiply and
// 1-bit/cycle logical shifts behind a Start/Busy/Done handshake.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_LSL = 3'b110,
        OP_LSR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SHIFT
    } state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               lsr_q, lsr_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    op_e                op;
    logic               is_sub;
    logic [WIDTH-1:0]   bx;
    logic [WIDTH:0]     sum;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] mul_nx;
    logic [WIDTH-1:0]   sh_nx;
    logic               sh_out;
    logic               fin;
    logic               fin_c;
    logic               fin_v;
    logic [WIDTH-1:0]   fin_res;

    always_comb begin
        op      = op_e'(bus.ALUControl);
        is_sub  = (op == OP_SUB);
        bx      = is_sub ? ~bus.b : bus.b;
        sum     = {1'b0, bus.a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
        shamt   = bus.b[SHW-1:0];
        // Upper half accumulates the multiplicand; the low half starts as the
        // multiplier and is consumed LSB-first as the product shifts in.
        mul_add = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_nx  = {mul_add, acc_q[WIDTH-1:1]};
        sh_nx   = lsr_q ? {1'b0, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
        sh_out  = lsr_q ? sh_q[0] : sh_q[WIDTH-1];

        state_d  = state_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        sh_d     = sh_q;
        lsr_d    = lsr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        flags_d  = flags_q;
        fin      = 1'b0;
        fin_c    = 1'b0;
        fin_v    = 1'b0;
        fin_res  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            fin     = 1'b1;
                            fin_res = sum[WIDTH-1:0];
                            fin_c   = sum[WIDTH];
                            fin_v   = (bus.a[WIDTH-1] == bx[WIDTH-1]) &&
                                      (sum[WIDTH-1] != bus.a[WIDTH-1]);
                        end
                        OP_AND: begin
                            fin     = 1'b1;
                            fin_res = bus.a & bus.b;
                        end
                        OP_OR: begin
                            fin     = 1'b1;
                            fin_res = bus.a | bus.b;
                        end
                        OP_XOR: begin
                            fin     = 1'b1;
                            fin_res = bus.a ^ bus.b;
                        end
                        OP_MUL: begin
                            acc_d   = {{WIDTH{1'b0}}, bus.b};
                            opa_d   = bus.a;
                            cnt_d   = SHW'(WIDTH - 1);
                            busy_d  = 1'b1;
                            state_d = S_MUL;
                        end
                        OP_LSL, OP_LSR: begin
                            if (shamt == '0) begin
                                fin     = 1'b1;
                                fin_res = bus.a;
                            end else begin
                                sh_d    = bus.a;
                                lsr_d   = (op == OP_LSR);
                                cnt_d   = shamt - SHW'(1);
                                busy_d  = 1'b1;
                                state_d = S_SHIFT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // The finish step is folded into the last iteration's edge so Done
            // lands in the cycle right after the final bit is processed.
            S_MUL: begin
                acc_d = mul_nx;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    fin     = 1'b1;
                    fin_res = mul_nx[WIDTH-1:0];
                    fin_c   = |mul_nx[2*WIDTH-1:WIDTH];
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                sh_d  = sh_nx;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    fin     = 1'b1;
                    fin_res = sh_nx;
                    fin_c   = sh_out;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            result_d = fin_res;
            flags_d  = {fin_res[WIDTH-1], (fin_res == '0), fin_c, fin_v};
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            opa_q    <= '0;
            sh_q     <= '0;
            lsr_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            sh_q     <= sh_d;
            lsr_q    <= lsr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Result   = result_q;
    assign bus.ALUFlags = flags_q;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset32;
    logic reset8;

    alu_mc_if #(.WIDTH(32)) bus32();
    alu_mc_if #(.WIDTH(8))  bus8();

    alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset32), .bus(bus32));
    alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset8),  .bus(bus8));

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          cyc;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          bf[2];
    int          bt[2];
    logic [31:0] last_res[2];
    logic [3:0]  last_flg[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Result/flags per the ALU rules, plus the cycle (1 = right after accept) in which Done shows.
    function automatic void ref_model(input int w, input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [3:0] f,
                                      output int k);
        logic [63:0] m, s, p;
        logic [31:0] bn;
        int          sh;
        logic        c, v;
        m  = (64'd1 << w) - 64'd1;
        c  = 1'b0;
        v  = 1'b0;
        k  = 1;
        r  = '0;
        sh = int'(b & 32'(w - 1));
        case (op)
            3'd0: begin
                s = {32'd0, a} + {32'd0, b};
                r = 32'(s & m);
                c = s[w];
                v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd1: begin
                bn = ~b & 32'(m);
                s  = {32'd0, a} + {32'd0, bn} + 64'd1;
                r  = 32'(s & m);
                c  = s[w];
                v  = (a[w-1] == bn[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                p = {32'd0, a} * {32'd0, b};
                r = 32'(p & m);
                c = ((p >> w) != 64'd0);
                k = w + 1;
            end
            3'd6: begin
                if (sh == 0) r = a;
                else begin
                    r = 32'(({32'd0, a} << sh) & m);
                    c = a[w-sh];
                end
                k = sh + 1;
            end
            default: begin
                r = a >> sh;
                c = (sh == 0) ? 1'b0 : a[sh-1];
                k = sh + 1;
            end
        endcase
        f = {r[w-1], (r == 32'd0), c, v};
    endfunction

    task automatic sb_check(input int id, input logic done, input logic busy,
                            input logic [31:0] res, input logic [3:0] flg);
        exp_t e;
        bit   have;
        logic exp_busy;
        have = (id == 0) ? (q32.size() > 0) : (q8.size() > 0);
        if (have) e = (id == 0) ? q32[0] : q8[0];
        exp_busy = (cyc >= bf[id]) && (cyc <= bt[id]);
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy w%0d cyc=%0d got=%b exp=%b", id, cyc, busy, exp_busy);
        end
        checks++;
        if (done === 1'b1) begin
            if (!have) begin
                errors++;
                $display("FAIL unexpected_done w%0d cyc=%0d got res=%h flags=%b", id, cyc, res, flg);
            end else begin
                if (id == 0) void'(q32.pop_front());
                else void'(q8.pop_front());
                if (res !== e.res || flg !== e.flg || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result w%0d got res=%h flags=%b cyc=%0d exp res=%h flags=%b cyc=%0d",
                             id, res, flg, cyc, e.res, e.flg, e.cyc);
                end
                last_res[id] = e.res;
                last_flg[id] = e.flg;
            end
        end else begin
            if (done !== 1'b0 || res !== last_res[id] || flg !== last_flg[id]) begin
                errors++;
                $display("FAIL hold w%0d cyc=%0d got done=%b res=%h flags=%b exp done=0 res=%h flags=%b",
                         id, cyc, done, res, flg, last_res[id], last_flg[id]);
            end
            if (have && e.cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_done w%0d cyc=%0d got none exp res=%h at cyc=%0d", id, cyc, e.res, e.cyc);
                if (id == 0) void'(q32.pop_front());
                else void'(q8.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        sb_check(0, bus32.Done, bus32.Busy, bus32.Result, bus32.ALUFlags);
        sb_check(1, bus8.Done, bus8.Busy, {24'd0, bus8.Result}, bus8.ALUFlags);
    end

    function automatic logic is_busy(input int id);
        return (id == 0) ? bus32.Busy : bus8.Busy;
    endfunction

    task automatic issue(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] am, bm, r;
        logic [3:0]  f;
        int          k, n, w;
        exp_t        e;
        w  = (id == 0) ? 32 : 8;
        am = (id == 0) ? a : {24'd0, a[7:0]};
        bm = (id == 0) ? b : {24'd0, b[7:0]};
        n  = 0;
        @(negedge clk);
        while (is_busy(id) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout w%0d got busy=1 exp busy=0 within 100 cycles", id);
        end
        if (id == 0) begin
            bus32.Start = 1'b1; bus32.ALUControl = op; bus32.a = am; bus32.b = bm;
        end else begin
            bus8.Start = 1'b1; bus8.ALUControl = op; bus8.a = am[7:0]; bus8.b = bm[7:0];
        end
        @(posedge clk);
        #1;
        bus32.Start = 1'b0;
        bus8.Start  = 1'b0;
        ref_model(w, op, am, bm, r, f, k);
        e.res = r;
        e.flg = f;
        e.cyc = cyc + k - 1;
        if (id == 0) q32.push_back(e);
        else q8.push_back(e);
        bf[id] = cyc;
        bt[id] = cyc + k - 2;
    endtask

    task automatic drain(input int id);
        int n;
        n = 0;
        while (((id == 0) ? q32.size() : q8.size()) > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (((id == 0) ? q32.size() : q8.size()) > 0) begin
            errors++;
            $display("FAIL drain w%0d got %0d pending exp 0", id, (id == 0) ? q32.size() : q8.size());
        end
    endtask

    initial begin
        int e0;
        bf = '{1, 1};
        bt = '{0, 0};
        last_res = '{32'd0, 32'd0};
        last_flg = '{4'd0, 4'd0};
        reset32 = 1'b1;
        reset8  = 1'b1;
        bus32.Start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.ALUControl = '0;
        bus8.Start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.ALUControl  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset32 = 1'b0;
        reset8  = 1'b0;

        issue(0, 3'd0, 32'h7FFF_FFFF, 32'h1);
        issue(0, 3'd1, 32'd5, 32'd5);

        issue(0, 3'd5, 32'h0001_0000, 32'h0001_0000);
        e0 = cyc;
        while (cyc < e0 + 4) @(negedge clk);
        bus32.Start = 1'b1; bus32.ALUControl = 3'd0; bus32.a = 32'd1; bus32.b = 32'd2;
        @(posedge clk);
        #1;
        bus32.Start = 1'b0;
        issue(0, 3'd5, 32'd7, 32'd6);

        issue(0, 3'd7, 32'h8000_0001, 32'd1);
        issue(0, 3'd7, 32'h8000_0001, 32'h20);
        issue(0, 3'd6, 32'd1, 32'd31);
        issue(0, 3'd4, 32'hFFFF_0000, 32'hFFFF_FFFF);
        issue(0, 3'd2, 32'hF0, 32'h0F);

        issue(0, 3'd5, $urandom, $urandom);
        e0 = cyc;
        while (cyc < e0 + 9) @(negedge clk);
        reset32 = 1'b1;
        @(posedge clk);
        #1;
        reset32 = 1'b0;
        q32.delete();
        bt[0] = cyc - 1;
        last_res[0] = '0;
        last_flg[0] = '0;
        issue(0, 3'd0, 32'd2, 32'd3);

        for (int i = 0; i < 60; i++) issue(0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        drain(0);

        issue(1, 3'd5, 32'h0F, 32'h11);
        issue(1, 3'd0, 32'hFF, 32'h01);
        issue(1, 3'd1, 32'h80, 32'h01);
        drain(1);
        @(negedge clk);
        bus8.Start = 1'b1; bus8.ALUControl = 3'd0; bus8.a = 8'd1; bus8.b = 8'd1;
        reset8 = 1'b1;
        @(posedge clk);
        #1;
        reset8 = 1'b0;
        bus8.Start = 1'b0;
        last_res[1] = '0;
        last_flg[1] = '0;
        for (int i = 0; i < 40; i++) issue(1, 3'($urandom_range(0, 7)), $urandom, $urandom);
        drain(1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the datapath's execute stage, replacing the fixed 32-bit, 2-bit-control combinational ALU. It adds XOR, an iterative shift-add multiply and iterative logical shifts. A Start/Busy/Done handshake lets the controller stall while a multi-cycle operation runs. Result and ALUFlags (N,Z,C,V) are registered and hold until the next operation completes.

## Interface
- WIDTH, 32: datapath width. Must be a power of two and ≥ 4.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- Start  in  1  request; accepted on a rising edge where Busy=0
- a, b  in  WIDTH  operands, sampled only at accept
- ALUControl  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 LSL, 111 LSR
- Busy  out  1  multi-cycle operation in progress
- Done  out  1  one-cycle pulse: Result/ALUFlags just updated
- Result  out  WIDTH  registered result
- ALUFlags  out  4  {N,Z,C,V}, registered

## Operation
- States:
  - IDLE: accepts Start; Busy=0.
  - MUL: a, b and the op are latched at accept; multiplies 1 bit/cycle.
  - SHIFT: a, b and the op are latched at accept; shifts 1 bit/cycle.
  - Finish: write Result/flags, pulse Done, return to IDLE.
- Accept in IDLE with Start=1:
  - ADD/SUB/AND/OR/XOR, or LSL/LSR with shamt=0, complete at the accepting edge (stay IDLE).
  - MUL enters MUL. LSL/LSR with shamt≠0 enters SHIFT.
- shamt = b[SHW-1:0]. Upper bits of b are ignored for shifts.
- MUL:
  - Unsigned shift-add over WIDTH iterations into a 2·WIDTH accumulator.
  - Result is the low WIDTH bits.
- Arithmetic: SUB = a + ~b + 1. All sums are WIDTH+1 bits; the carry out is bit WIDTH.
- Flags:
  - N = Result[WIDTH-1]. Z = (Result == 0).
  - C for ADD: carry out. C for SUB: carry out (1 = no borrow, a ≥ b unsigned).
  - C for LSL/LSR: last bit shifted out; 0 when shamt=0.
  - C for MUL: 1 iff the high WIDTH bits of the product are nonzero.
  - C for AND/OR/XOR: 0.
  - V for ADD/SUB: signed overflow, i.e. operand signs (b inverted for SUB) equal and Result sign differs. V is 0 for all other ops.
- Start while Busy=1 is ignored. It is not queued.
- Changes on a, b or ALUControl while Busy=1 have no effect.
- Result/ALUFlags never show partial values. They change only in the cycle Done rises.
- Reset value of every output: Result=0, ALUFlags=0000, Busy=0, Done=0. State returns to IDLE.
- reset mid-operation: aborts the operation, no Done is produced, and outputs return to their reset values on the next edge.
- Start together with reset: reset wins and the request is dropped.

## Timing
- Edge 0 is the accepting edge; cycle k is the cycle after edge k.
- Single-cycle ops: Done=1 with the new Result in cycle 1. Busy stays 0.
- Back-to-back: with Start held high, single-cycle ops accept and complete once per cycle.
- MUL:
  - Busy=1 in cycles 1..WIDTH.
  - Done=1, Busy=0 and the new Result in cycle WIDTH+1. A new Start is accepted at the edge ending that cycle.
- LSL/LSR:
  - Busy=1 in cycles 1..shamt.
  - Done in cycle shamt+1. shamt=0 gives Done in cycle 1.
- Done is high for exactly one cycle per accepted operation.

## Test plan
- WIDTH=32, ADD a=0x7FFFFFFF, b=1:
  - Done in cycle 1, Result=0x80000000, ALUFlags=1001.
  - Then SUB a=b=5 back-to-back: Result=0, ALUFlags=0110 in cycle 2.
- MUL a=0x00010000, b=0x00010000:
  - Busy cycles 1..32; an ADD Start pulsed in cycle 5 is ignored.
  - Done in cycle 33, Result=0, ALUFlags=0110.
  - MUL 7×6 gives Result=42, ALUFlags=0000.
- LSR a=0x80000001:
  - shamt=1: Done in cycle 2, Result=0x40000000, ALUFlags=0010.
  - b=0x20 (shamt=0): Done in cycle 1, Result=0x80000001, ALUFlags=1000.
  - LSL a=1, shamt=31: Done in cycle 32, Result=0x80000000, ALUFlags=1000.
- XOR a=0xFFFF0000, b=0xFFFFFFFF: Result=0x0000FFFF, ALUFlags=0000. AND 0xF0 & 0x0F: Z=1, ALUFlags=0100.
- Reset in cycle 10 of a MUL:
  - Next cycle: Busy=0, Done=0, Result=0, ALUFlags=0000. No Done ever appears for the aborted MUL.
  - A following ADD 2+3 gives Result=5 in cycle 1.
- WIDTH=8:
  - MUL 0x0F×0x11: Done in cycle 9, Result=0xFF, ALUFlags=1000.
  - ADD 0xFF+0x01: Result=0x00, ALUFlags=0110.
